// File: rtl/instr_wb_pkg.sv
// Shared types and widths for the pipelined Wishbone instruction-fetch master.
// The master, its bus interface and the timeout counter all import this package.
package instr_wb_pkg;

   localparam int ADR_W = 32;
   localparam int DAT_W = 32;
   localparam int SEL_W = 4;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQUEST  = 2'd1,
      WAIT_ACK = 2'd2,
      RESPONSE = 2'd3
   } state_t;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/instr_wb_if.sv
// Pipelined Wishbone bus bundle between the master and a slave.
// Signal names are from the master's point of view.
interface instr_wb_if;
   import instr_wb_pkg::*;

   logic [ADR_W-1:0] wb_adr_o;
   logic [DAT_W-1:0] wb_dat_o;
   logic [DAT_W-1:0] wb_dat_i;
   logic             wb_we_o;
   logic [SEL_W-1:0] wb_sel_o;
   logic             wb_stb_o;
   logic             wb_ack_i;
   logic             wb_cyc_o;
   logic             wb_stall_i;

   modport master (
      output wb_adr_o,
      output wb_dat_o,
      output wb_we_o,
      output wb_sel_o,
      output wb_stb_o,
      output wb_cyc_o,
      input  wb_dat_i,
      input  wb_ack_i,
      input  wb_stall_i
   );

   modport slave (
      input  wb_adr_o,
      input  wb_dat_o,
      input  wb_we_o,
      input  wb_sel_o,
      input  wb_stb_o,
      input  wb_cyc_o,
      output wb_dat_i,
      output wb_ack_i,
      output wb_stall_i
   );

endinterface

// File: rtl/instr_wb_timeout.sv
// Cycle counter that flags a bus transaction running too long.
// It is held at zero while clear is high and counts while enable is high.
module instr_wb_timeout
   import instr_wb_pkg::*;
#(
   parameter logic [CNT_W-1:0] TIMEOUT = 16'd64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic enable,
   input  logic clear,
   output logic expired
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= sat_inc(count);
      end
   end

   // A TIMEOUT of zero means the transaction may wait forever.
   assign expired = enable && (TIMEOUT != '0) && (count >= TIMEOUT);

endmodule

// File: rtl/instr_wb_master.sv
// Single-outstanding pipelined Wishbone master: accepts one request, drives it onto
// the bus, then returns a one-cycle response carrying the read data or a timeout error.
module instr_wb_master
   import instr_wb_pkg::*;
#(
   parameter logic [CNT_W-1:0] TIMEOUT = 16'd64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   instr_wb_if.master       wb,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [ADR_W-1:0] req_adr_i,
   input  logic [DAT_W-1:0] req_dat_i,
   input  logic             req_we_i,
   input  logic [SEL_W-1:0] req_sel_i,
   output logic             rsp_valid_o,
   output logic [DAT_W-1:0] rsp_dat_o,
   output logic             rsp_err_o,
   output logic [CNT_W-1:0] stall_count_o
);

   state_t           state_q,       state_n;
   logic             cyc_q,         cyc_n;
   logic             stb_q,         stb_n;
   logic             we_q,          we_n;
   logic [ADR_W-1:0] adr_q,         adr_n;
   logic [DAT_W-1:0] dat_q,         dat_n;
   logic [SEL_W-1:0] sel_q,         sel_n;
   logic             rsp_valid_q,   rsp_valid_n;
   logic             rsp_err_q,     rsp_err_n;
   logic [DAT_W-1:0] rsp_dat_q,     rsp_dat_n;
   logic [CNT_W-1:0] stall_count_q, stall_count_n;

   logic busy;
   logic expired;
   logic ack_taken;

   assign busy = (state_q == REQUEST) || (state_q == WAIT_ACK);

   instr_wb_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .enable  (busy),
      .clear   (!busy),
      .expired (expired)
   );

   // While the slave stalls the strobe has not been accepted, so an ack then is bogus.
   assign ack_taken = ((state_q == REQUEST) && !wb.wb_stall_i && wb.wb_ack_i) ||
                      ((state_q == WAIT_ACK) && wb.wb_ack_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         cyc_q         <= 1'b0;
         stb_q         <= 1'b0;
         we_q          <= 1'b0;
         adr_q         <= '0;
         dat_q         <= '0;
         sel_q         <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_err_q     <= 1'b0;
         rsp_dat_q     <= '0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_n;
         cyc_q         <= cyc_n;
         stb_q         <= stb_n;
         we_q          <= we_n;
         adr_q         <= adr_n;
         dat_q         <= dat_n;
         sel_q         <= sel_n;
         rsp_valid_q   <= rsp_valid_n;
         rsp_err_q     <= rsp_err_n;
         rsp_dat_q     <= rsp_dat_n;
         stall_count_q <= stall_count_n;
      end
   end

   // An honoured ack beats a timeout that expires in the same cycle.
   always_comb begin
      state_n       = state_q;
      cyc_n         = cyc_q;
      stb_n         = stb_q;
      we_n          = we_q;
      adr_n         = adr_q;
      dat_n         = dat_q;
      sel_n         = sel_q;
      rsp_valid_n   = 1'b0;
      rsp_err_n     = 1'b0;
      rsp_dat_n     = rsp_dat_q;
      stall_count_n = stall_count_q;

      if ((state_q == REQUEST) && wb.wb_stall_i) begin
         stall_count_n = sat_inc(stall_count_q);
      end

      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               state_n       = REQUEST;
               cyc_n         = 1'b1;
               stb_n         = 1'b1;
               we_n          = req_we_i;
               adr_n         = req_adr_i;
               dat_n         = req_dat_i;
               sel_n         = req_sel_i;
               stall_count_n = '0;
            end
         end

         REQUEST, WAIT_ACK: begin
            if (ack_taken) begin
               state_n     = RESPONSE;
               cyc_n       = 1'b0;
               stb_n       = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_dat_n   = we_q ? '0 : wb.wb_dat_i;
            end else if (expired) begin
               state_n     = RESPONSE;
               cyc_n       = 1'b0;
               stb_n       = 1'b0;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b1;
               rsp_dat_n   = '0;
            end else if ((state_q == REQUEST) && !wb.wb_stall_i) begin
               state_n = WAIT_ACK;
               stb_n   = 1'b0;
            end
         end

         RESPONSE: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
         end
      endcase
   end

   assign req_ready_o   = (state_q == IDLE);

   assign wb.wb_cyc_o   = cyc_q;
   assign wb.wb_stb_o   = stb_q;
   assign wb.wb_we_o    = we_q;
   assign wb.wb_adr_o   = adr_q;
   assign wb.wb_dat_o   = dat_q;
   assign wb.wb_sel_o   = sel_q;

   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_err_o     = rsp_err_q;
   assign rsp_dat_o     = rsp_dat_q;
   assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_instr_wb_master.sv
// Randomised bench for instr_wb_master: each transaction's outcome (response cycle,
// error, data, stall count) is predicted from the slave's stall/ack plan up front.
module tb_instr_wb_master;
   import instr_wb_pkg::*;

   localparam int              TMO_CYCLES = 8;
   localparam logic [CNT_W-1:0] TMO       = 16'(TMO_CYCLES);
   localparam int              NO_ACK     = 1000;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready_o;
   logic [ADR_W-1:0] req_adr;
   logic [DAT_W-1:0] req_dat;
   logic             req_we;
   logic [SEL_W-1:0] req_sel;
   logic             rsp_valid_o;
   logic [DAT_W-1:0] rsp_dat_o;
   logic             rsp_err_o;
   logic [CNT_W-1:0] stall_count_o;

   int checkCount = 0;
   int errorCount = 0;

   instr_wb_if wbBus ();

   instr_wb_master #(
      .TIMEOUT (TMO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .wb            (wbBus),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready_o),
      .req_adr_i     (req_adr),
      .req_dat_i     (req_dat),
      .req_we_i      (req_we),
      .req_sel_i     (req_sel),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_dat_o     (rsp_dat_o),
      .rsp_err_o     (rsp_err_o),
      .stall_count_o (stall_count_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   task automatic waitReady;
      int waitCnt;
      waitCnt = 0;
      while (!req_ready_o && waitCnt < 20) begin
         nextCycle();
         waitCnt++;
      end
      checkOutput("readyBeforeReq", 32'(req_ready_o), 32'd1);
   endtask

   // Cycle k counts from the first REQUEST cycle; the slave stalls cycles 0..stalls-1
   // and raises ack in cycles ackA and ackB.
   task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                                input logic [3:0] sel, input int stalls, input int ackA,
                                input int ackB, input logic [31:0] rdata, input bit noisyValid);
      int          firstAck;
      int          endCycle;
      int          expStall;
      logic [31:0] expData;
      logic        expErr;
      bit          done;

      waitReady();
      req_valid = 1'b1;
      req_adr   = adr;
      req_dat   = dat;
      req_we    = we;
      req_sel   = sel;
      nextCycle();

      firstAck = NO_ACK;
      if (ackA >= stalls && ackA < firstAck) firstAck = ackA;
      if (ackB >= stalls && ackB < firstAck) firstAck = ackB;
      if (firstAck != NO_ACK && firstAck <= TMO_CYCLES) begin
         endCycle = firstAck;
         expErr   = 1'b0;
         expData  = we ? 32'h0 : rdata;
      end else begin
         endCycle = TMO_CYCLES;
         expErr   = 1'b1;
         expData  = 32'h0;
      end
      expStall = (stalls < endCycle + 1) ? stalls : endCycle + 1;

      if (noisyValid) begin
         req_adr = $urandom;
         req_dat = $urandom;
         req_we  = ~we;
         req_sel = ~sel;
      end else begin
         req_valid = 1'b0;
      end

      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         if (rsp_valid_o) begin
            done = 1'b1;
            checkOutput("respCycle", 32'(k), 32'(endCycle + 1));
            checkOutput("rspErr", 32'(rsp_err_o), 32'(expErr));
            checkOutput("rspDat", rsp_dat_o, expData);
            checkOutput("stallCount", 32'(stall_count_o), 32'(expStall));
            checkOutput("cycAtRsp", 32'(wbBus.wb_cyc_o), 32'd0);
            checkOutput("stbAtRsp", 32'(wbBus.wb_stb_o), 32'd0);
            wbBus.wb_ack_i   = 1'b0;
            wbBus.wb_stall_i = 1'b0;
            req_valid        = 1'b0;
         end else begin
            checkOutput("cycBusy", 32'(wbBus.wb_cyc_o), 32'd1);
            checkOutput("stbBusy", 32'(wbBus.wb_stb_o), 32'(k <= stalls));
            checkOutput("adrHeld", wbBus.wb_adr_o, adr);
            checkOutput("datHeld", wbBus.wb_dat_o, dat);
            checkOutput("weHeld", 32'(wbBus.wb_we_o), 32'(we));
            checkOutput("selHeld", 32'(wbBus.wb_sel_o), 32'(sel));
            checkOutput("readyBusy", 32'(req_ready_o), 32'd0);
            checkOutput("stallCountRun", 32'(stall_count_o), 32'((k < stalls) ? k : stalls));
            wbBus.wb_stall_i = (k < stalls);
            wbBus.wb_ack_i   = (k == ackA) || (k == ackB);
            wbBus.wb_dat_i   = wbBus.wb_ack_i ? rdata : $urandom;
            nextCycle();
         end
      end
      if (!done) begin
         checkOutput("respMissing", 32'd0, 32'd1);
         wbBus.wb_ack_i   = 1'b0;
         wbBus.wb_stall_i = 1'b0;
         req_valid        = 1'b0;
      end
      nextCycle();
      checkOutput("rspPulseEnd", 32'(rsp_valid_o), 32'd0);
      checkOutput("rspErrClear", 32'(rsp_err_o), 32'd0);
      checkOutput("readyAfterRsp", 32'(req_ready_o), 32'd1);
   endtask

   // Reset lands in the middle of WAIT_ACK; the bus must drop at once with no response.
   task automatic applyMidReset;
      waitReady();
      req_valid = 1'b1;
      req_adr   = 32'h0000_2000;
      req_we    = 1'b0;
      req_sel   = 4'hF;
      nextCycle();
      req_valid        = 1'b0;
      wbBus.wb_stall_i = 1'b0;
      wbBus.wb_ack_i   = 1'b0;
      nextCycle();
      checkOutput("cycInWait", 32'(wbBus.wb_cyc_o), 32'd1);
      nextCycle();
      #2 rst = 1'b1;
      #1;
      checkOutput("cycAsyncRst", 32'(wbBus.wb_cyc_o), 32'd0);
      checkOutput("stbAsyncRst", 32'(wbBus.wb_stb_o), 32'd0);
      checkOutput("adrAsyncRst", wbBus.wb_adr_o, 32'h0);
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         checkOutput("noRspInRst", 32'(rsp_valid_o), 32'd0);
      end
      rst = 1'b0;
      checkOutput("readyAtRelease", 32'(req_ready_o), 32'd1);
      nextCycle();
      checkOutput("readyAfterRelease", 32'(req_ready_o), 32'd1);
      checkOutput("noRspAfterRelease", 32'(rsp_valid_o), 32'd0);
   endtask

   initial begin
      rst              = 1'b1;
      req_valid        = 1'b0;
      req_adr          = '0;
      req_dat          = '0;
      req_we           = 1'b0;
      req_sel          = '0;
      wbBus.wb_dat_i   = '0;
      wbBus.wb_ack_i   = 1'b0;
      wbBus.wb_stall_i = 1'b0;

      #3;
      checkOutput("rstCyc", 32'(wbBus.wb_cyc_o), 32'd0);
      checkOutput("rstStb", 32'(wbBus.wb_stb_o), 32'd0);
      checkOutput("rstWe", 32'(wbBus.wb_we_o), 32'd0);
      checkOutput("rstSel", 32'(wbBus.wb_sel_o), 32'd0);
      checkOutput("rstAdr", wbBus.wb_adr_o, 32'h0);
      checkOutput("rstDat", wbBus.wb_dat_o, 32'h0);
      checkOutput("rstRspValid", 32'(rsp_valid_o), 32'd0);
      checkOutput("rstRspErr", 32'(rsp_err_o), 32'd0);
      checkOutput("rstRspDat", rsp_dat_o, 32'h0);
      checkOutput("rstStallCount", 32'(stall_count_o), 32'd0);
      nextCycle();
      nextCycle();
      rst = 1'b0;
      nextCycle();
      checkOutput("rstReady", 32'(req_ready_o), 32'd1);

      // Plain read, ack one cycle after the transfer.
      applyStimulus(32'h0000_0040, 32'h0, 1'b0, 4'hF, 0, 1, NO_ACK, 32'hDEADBEEF, 1'b0);
      // Write with three stall cycles and a bogus ack during the stall.
      applyStimulus(32'h0000_0100, 32'hA5A5A5A5, 1'b1, 4'b0011, 3, 4, 1, 32'h1234_5678, 1'b0);
      // Same-cycle ack with the transfer.
      applyStimulus(32'h0000_0200, 32'h0, 1'b0, 4'hF, 0, 0, NO_ACK, 32'hCAFE_F00D, 1'b1);
      // Ack only while stalled is ignored, so the request times out.
      applyStimulus(32'h0000_0300, 32'h0, 1'b0, 4'hF, 2, 1, NO_ACK, 32'h5555_AAAA, 1'b0);
      // Ignored stalled ack followed by a real one at the transfer.
      applyStimulus(32'h0000_0304, 32'h0, 1'b0, 4'hF, 2, 1, 2, 32'h0BAD_F00D, 1'b0);
      // Silent slave times out; ack exactly at the limit still wins; one cycle later does not.
      applyStimulus(32'h0000_0400, 32'h0, 1'b0, 4'hF, 0, NO_ACK, NO_ACK, 32'h0, 1'b0);
      applyStimulus(32'h0000_0404, 32'h0, 1'b0, 4'hF, 0, TMO_CYCLES, NO_ACK, 32'h8888_7777, 1'b0);
      applyStimulus(32'h0000_0408, 32'h0, 1'b0, 4'hF, 0, TMO_CYCLES + 1, NO_ACK, 32'h8888_7777, 1'b0);
      // Stalling past the limit.
      applyStimulus(32'h0000_0500, 32'h0F0F_0F0F, 1'b1, 4'b1100, 11, 11, NO_ACK, 32'h0, 1'b0);

      applyMidReset();
      applyStimulus(32'h0000_0600, 32'h0, 1'b0, 4'hF, 1, 3, NO_ACK, 32'h1357_9BDF, 1'b0);

      for (int t = 0; t < 40; t++) begin
         applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 10)), int'($urandom_range(0, 12)),
                       ($urandom_range(0, 1) == 1) ? NO_ACK : int'($urandom_range(0, 12)),
                       $urandom, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/instr_wb_master.md
INSTR_WB_MASTER -- requirements
Module: instr_wb_master

Interface
REQ-001 Parameter TIMEOUT, default 16'd64, max cycles from request issue to ack before abort; 0 disables the timeout.
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous and active-high.
REQ-004 wb_adr_o  output  32  Wishbone address.
REQ-005 wb_dat_o  output  32  Wishbone write data.
REQ-006 wb_dat_i  input  32  Wishbone read data.
REQ-007 wb_we_o  output  1  write enable.
REQ-008 wb_sel_o  output  4  byte select.
REQ-009 wb_stb_o  output  1  strobe.
REQ-010 wb_ack_i  input  1  acknowledge.
REQ-011 wb_cyc_o  output  1  cycle.
REQ-012 wb_stall_i  input  1  pipelined stall.
REQ-013 req_valid_i  input  1  testbench request valid.
REQ-014 req_ready_o  output  1  block accepts a request.
REQ-015 req_adr_i, req_dat_i  input  32 each  request address, write data.
REQ-016 req_we_i  input  1; req_sel_i  input  4  request direction, byte select.
REQ-017 rsp_valid_o  output  1  one-cycle response pulse.
REQ-018 rsp_dat_o  output  32  read data captured at ack.
REQ-019 rsp_err_o  output  1  response terminated by timeout.
REQ-020 stall_count_o  output  16  stall cycles seen in the current/last transaction, saturating.

Function
REQ-021 States SHALL be IDLE, REQUEST, WAIT_ACK, RESPONSE; all Wishbone outputs registered.
REQ-022 req_ready_o SHALL be 1 only in IDLE; handshake = req_valid_i && req_ready_o.
REQ-023 On handshake, next cycle: state REQUEST, wb_cyc_o=1, wb_stb_o=1, adr/dat/we/sel latched from req_*; stall_count_o cleared to 0.
REQ-024 In REQUEST with wb_stall_i=1: outputs held stable, stall_count_o +1 (saturates at 16'hFFFF).
REQ-025 In REQUEST with wb_stall_i=0: request transferred; next cycle wb_stb_o=0, wb_cyc_o=1, state WAIT_ACK.
REQ-026 wb_ack_i in REQUEST is honoured only when wb_stall_i=0 (same-cycle ack), going directly to RESPONSE; ack while stalled is ignored.
REQ-027 On honoured ack: rsp_dat_o <= wb_dat_i for reads, 32'h0 for writes; next cycle state RESPONSE, wb_cyc_o=0, wb_stb_o=0.
REQ-028 RESPONSE SHALL last exactly one cycle with rsp_valid_o=1, then IDLE; minimum request-to-response latency = 3 cycles.
REQ-029 Timeout counter SHALL start at 0 on entering REQUEST, increment every cycle in REQUEST/WAIT_ACK; reaching TIMEOUT without ack: cyc/stb drop next cycle, RESPONSE with rsp_err_o=1, rsp_dat_o=0.
REQ-030 Ack in the same cycle the counter reaches TIMEOUT SHALL win (rsp_err_o=0).
REQ-031 rsp_err_o SHALL be 0 on non-timeout responses and valid only while rsp_valid_o=1.
REQ-032 req_valid_i outside IDLE SHALL be ignored; no request queueing.

Reset
REQ-033 While rst_i=1, asynchronously: state IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, wb_sel_o=0, rsp_valid_o=rsp_err_o=0, rsp_dat_o=0, stall_count_o=0, timeout counter 0.
REQ-034 Reset mid-transaction SHALL abort with no response pulse; req_ready_o=1 first cycle after release.

Structure
REQ-035 Package instr_wb_pkg SHALL hold the state enum and the 32/4/16-bit width localparams.
REQ-036 Timeout counter SHALL be one sub-module instr_wb_timeout (enable, clear, TIMEOUT parameter, expired output).

Verification
REQ-037 Read, no stall, ack 1 cycle after transfer, wb_dat_i=32'hDEADBEEF -> rsp_valid_o one cycle, rsp_dat_o=32'hDEADBEEF, rsp_err_o=0.
REQ-038 Write adr 32'h100, dat 32'hA5A5A5A5, sel 4'b0011, stall 3 cycles -> outputs stable during stall, stall_count_o=3, rsp_dat_o=0.
REQ-039 Same-cycle ack with stall=0 -> response 3 cycles after handshake; ack while stall=1 ignored.
REQ-040 TIMEOUT=8, no ack -> cyc drops, rsp_err_o=1 with rsp_valid_o; ack exactly at count 8 -> rsp_err_o=0.
REQ-041 rst_i pulsed mid-WAIT_ACK -> wb_cyc_o=0 immediately, no rsp_valid_o, next request completes normally.
